// File: rtl/jpeg_zigzag_reader.sv
// jpeg_zigzag_reader: collects raster-order 8x8 DCT blocks into two ping-pong
// banks and replays each completed block in JPEG zig-zag order through a
// single registered output stage with valid/ready handshake.
module jpeg_zigzag_reader #(
  parameter int unsigned DW       = 12,
  parameter int unsigned ZZ_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [DW-1:0] din,
  input  logic          din_en,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          dout_sob,
  output logic          dout_eob,
  output logic          ovf
);

  localparam int unsigned PW = 6;

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_READING = 2'd3
  } bank_st_e;

  // Raster index of the n-th coefficient in zig-zag order.
  localparam logic [PW-1:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DW-1:0] mem_q [2][64];
  bank_st_e      bst_q [2];
  logic          wbank_q, rbank_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [DW-1:0] dout_q;
  logic          dout_vld_q, dout_sob_q, dout_eob_q, ovf_q;

  logic          wr_ok, rd_avail, out_load;
  logic [PW-1:0] zz_idx;

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_sob = dout_sob_q;
  assign dout_eob = dout_eob_q;
  assign ovf      = ovf_q;

  // Bank availability, output-stage load condition and zig-zag address.
  always_comb begin
    wr_ok    = (bst_q[wbank_q] == B_EMPTY) || (bst_q[wbank_q] == B_FILLING);
    rd_avail = (bst_q[rbank_q] == B_FULL) || (bst_q[rbank_q] == B_READING);
    out_load = !dout_vld_q || dout_rdy;
    zz_idx   = (ZZ_FIRST != 32'd0) ? ZZ[rptr_q] : ZZ[~rptr_q];
  end

  // Coefficient storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst && ena && din_en && wr_ok) begin
      mem_q[wbank_q][wptr_q] <= din;
    end
  end

  // Bank state machines, pointers, overflow flag and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bst_q[0]   <= B_EMPTY;
      bst_q[1]   <= B_EMPTY;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_sob_q <= 1'b0;
      dout_eob_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (ena) begin
      // Write side: fill current bank, hand it over on wrap, else flag overflow.
      if (din_en) begin
        if (wr_ok) begin
          wptr_q <= PW'(wptr_q + 6'd1);
          if (wptr_q == 6'd63) begin
            bst_q[wbank_q] <= B_FULL;
            wbank_q        <= ~wbank_q;
          end else begin
            bst_q[wbank_q] <= B_FILLING;
          end
        end else begin
          ovf_q <= 1'b1;
        end
      end
      // Read side: fetch one zig-zag coefficient whenever the output can take it.
      if (out_load) begin
        if (rd_avail) begin
          dout_q     <= mem_q[rbank_q][zz_idx];
          dout_vld_q <= 1'b1;
          dout_sob_q <= (rptr_q == 6'd0);
          dout_eob_q <= (rptr_q == 6'd63);
          rptr_q     <= PW'(rptr_q + 6'd1);
          if (rptr_q == 6'd63) begin
            bst_q[rbank_q] <= B_EMPTY;
            rbank_q        <= ~rbank_q;
          end else begin
            bst_q[rbank_q] <= B_READING;
          end
        end else begin
          dout_vld_q <= 1'b0;
          dout_sob_q <= 1'b0;
          dout_eob_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_zigzag_reader.sv
// Directed bench for jpeg_zigzag_reader: expected output stream is built from
// the zig-zag table and the block base values the bench itself writes.
module tb_jpeg_zigzag_reader;

  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          rst, ena, din_en, dout_rdy;
  logic [DW-1:0] din, dout;
  logic          dout_vld, dout_sob, dout_eob, ovf;

  int   errors  = 0;
  int   checks  = 0;
  int   n_out   = 0;
  bit   started = 1'b0;
  logic exp_ovf = 1'b0;

  int zz [64] = '{
    0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,
    35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63
  };

  logic [DW-1:0] exp_d [$];
  int            exp_i [$];

  always #5 clk = ~clk;

  jpeg_zigzag_reader #(.DW(DW), .ZZ_FIRST(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .din_en(din_en),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout_sob(dout_sob), .dout_eob(dout_eob), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input int base);
    for (int i = 0; i < 64; i++) begin
      exp_d.push_back(DW'(base + zz[i]));
      exp_i.push_back(i);
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic tick(input logic r, input logic e, input logic en,
                      input logic [DW-1:0] d, input logic rdy);
    @(negedge clk);
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    if (started && exp_d.size() != 0) chk("vld_contig", 32'(dout_vld), 32'd1);
    if (dout_vld === 1'b1) begin
      started = 1'b1;
      if (exp_d.size() == 0) begin
        chk("spurious_vld", 32'(dout_vld), 32'd0);
      end else begin
        chk("dout", 32'(dout), 32'(exp_d[0]));
        chk("sob", 32'(dout_sob), 32'(exp_i[0] == 0));
        chk("eob", 32'(dout_eob), 32'(exp_i[0] == 63));
      end
    end
    rst = r; ena = e; din_en = en; din = d; dout_rdy = rdy;
    if (!r) begin
      exp_d.delete();
      exp_i.delete();
      exp_ovf = 1'b0;
      started = 1'b0;
    end else if (e && rdy && dout_vld === 1'b1 && exp_d.size() != 0) begin
      void'(exp_d.pop_front());
      void'(exp_i.pop_front());
      n_out++;
      if (exp_d.size() == 0) started = 1'b0;
    end
  endtask

  // Write n coefficients base+k; mode 0: rdy=1, 1: rdy toggles 1010, 2: rdy=0.
  task automatic feed(input int base, input int k0, input int n, input int mode);
    for (int j = 0; j < n; j++) begin
      int k;
      logic rdy;
      k = k0 + j;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(j % 2 == 0) : 1'b0;
      tick(1'b1, 1'b1, 1'b1, DW'(base + k), rdy);
      if (k == 63) push_block(base);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_d.size() != 0 || dout_vld === 1'b1) && i < 400) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1'b1);
      i++;
    end
    chk("drain_timeout", 32'(i < 400), 32'd1);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; din_en = 1'b0; din = '0; dout_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_vld", 32'(dout_vld), 32'd0);
    chk("rst_sob", 32'(dout_sob), 32'd0);
    chk("rst_eob", 32'(dout_eob), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Single block: latency N+2 to DC, then full zig-zag stream.
    n_out = 0;
    feed(0, 0, 64, 0);
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("lat_n1_vld", 32'(dout_vld), 32'd0);
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("lat_n2_vld", 32'(dout_vld), 32'd1);
    chk("lat_n2_dc", 32'(dout), 32'd0);
    chk("lat_n2_sob", 32'(dout_sob), 32'd1);
    drain();
    chk("blk1_count", 32'(n_out), 32'd64);

    // Three back-to-back blocks at full rate.
    n_out = 0;
    feed(0, 0, 64, 0);
    feed(100, 0, 64, 0);
    feed(200, 0, 64, 0);
    drain();
    chk("b2b_count", 32'(n_out), 32'd192);
    chk("b2b_ovf", 32'(ovf), 32'd0);

    // Ready toggling on block 1 while block 2 streams in.
    n_out = 0;
    feed(300, 0, 64, 0);
    feed(400, 0, 64, 1);
    drain();
    chk("tog_count", 32'(n_out), 32'd128);
    chk("tog_ovf", 32'(ovf), 32'd0);

    // Ready held low: two banks fill, the 129th sample is dropped.
    n_out = 0;
    feed(-1000, 0, 64, 2);
    feed(1000, 0, 64, 2);
    chk("pre_ovf", 32'(ovf), 32'd0);
    tick(1'b1, 1'b1, 1'b1, 12'h7ff, 1'b0);
    exp_ovf = 1'b1;
    repeat (4) tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    drain();
    chk("ovf_count", 32'(n_out), 32'd128);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Reset after a partial block; only the fresh block should emerge.
    n_out = 0;
    feed(700, 0, 30, 0);
    tick(1'b0, 1'b1, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("mrst_dout", 32'(dout), 32'd0);
    chk("mrst_vld", 32'(dout_vld), 32'd0);
    chk("mrst_sob", 32'(dout_sob), 32'd0);
    chk("mrst_eob", 32'(dout_eob), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    feed(800, 0, 64, 0);
    drain();
    chk("mrst_count", 32'(n_out), 32'd64);

    // Clock-enable low for 5 cycles mid-output with inputs toggling.
    n_out = 0;
    feed(50, 0, 64, 0);
    feed(150, 0, 10, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, logic'(i % 2 == 0), 12'habc, logic'(i % 2 == 1));
    end
    chk("ena_hold_vld", 32'(dout_vld), 32'd1);
    feed(150, 10, 54, 0);
    drain();
    chk("ena_count", 32'(n_out), 32'd128);
    chk("ena_ovf", 32'(ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
